bin2bcd_converter: RTL and testbench
====================================

Name: bin2bcd_converter

Overview:
Sequential double-dabble converter placed directly downstream of the restoring divider. When the divider's done pulse arrives, it captures the 16-bit quotient and remainder and converts both to packed BCD in parallel, one shift per clock. The result drives the seven-segment display path, so the display shows decimal values instead of hex. It also flags values that cannot fit on the 4-digit display field.

Parameters:
WIDTH, 16, bit width of each binary operand.
DIGITS, 5, BCD digits per operand. Must satisfy 10^DIGITS > 2^WIDTH - 1.
DISP_DIGITS, 4, digits available per operand on the display; sets the overflow threshold.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  one-cycle pulse: quotient/remainder are valid (driven by the divider's valid)
quotient  input  WIDTH  binary quotient
remainder  input  WIDTH  binary remainder
busy  output  1  high while a conversion is in progress (state != IDLE)
out_valid  output  1  one-cycle pulse: BCD outputs updated
q_bcd  output  4*DIGITS  packed BCD of quotient, digit 0 = LSD in bits [3:0]
r_bcd  output  4*DIGITS  packed BCD of remainder, same packing
q_ovf  output  1  quotient >= 10^DISP_DIGITS
r_ovf  output  1  remainder >= 10^DISP_DIGITS

Behaviour:
- Reset (asynchronous, active-high, any time including mid-conversion):
  - state = IDLE, shift counter = 0, scratch registers = 0.
  - busy = 0, out_valid = 0, q_bcd = r_bcd = 0, q_ovf = r_ovf = 0.
- Scratch register per operand: {bcd[4*DIGITS-1:0], bin[WIDTH-1:0]}. Two independent datapaths (quotient and remainder) run in lockstep.
- FSM states:
  - IDLE: busy = 0. On in_valid at clock edge E:
    - bin <= operand, bcd <= 0, count <= 0, go to SHIFT.
    - in_valid while not in IDLE is ignored. No queueing, no effect on the current conversion.
  - SHIFT: one iteration per edge.
    - First, every BCD digit >= 5 gets +3 (4-bit add, no carry between digits).
    - Then the whole scratch register shifts left by 1.
    - count increments. The edge that performs iteration WIDTH (count == WIDTH-1) moves to DONE.
    - With default width, SHIFT iterations occur at edges E+1 .. E+16.
  - DONE (one cycle):
    - At edge E+WIDTH+1: q_bcd/r_bcd <= bcd fields, ovf flags are computed, out_valid <= 1, go to IDLE.
- Latency and hold:
  - out_valid is high exactly during the cycle after edge E+WIDTH+1: E+17 to E+18 at default width.
  - Outputs hold their last value until the next completion. They are never cleared by a new capture.
- Overflow: q_ovf = 1 iff any of q_bcd digits DISP_DIGITS .. DIGITS-1 is nonzero. r_ovf is defined the same way on r_bcd.
- Back-to-back: busy is low during the out_valid cycle. An in_valid in that cycle is accepted at edge E+WIDTH+2 and starts a fresh conversion.
- A BCD digit must never exceed 9 after any shift. This is a required assertion.
- The divider's divide-by-zero pulse (quotient 0, remainder = dividend) is converted like any other input.

Test Plan:
1. Reset, then in_valid with quotient=16'd4660, remainder=16'd7 -> exactly 17 cycles later out_valid=1 for 1 cycle; q_bcd=20'h04660, r_bcd=20'h00007, q_ovf=r_ovf=0; busy high for 17 cycles.
2. quotient=16'hFFFF, remainder=16'd10000 -> q_bcd=20'h65535, r_bcd=20'h10000, q_ovf=1, r_ovf=1. Also check boundary remainder=16'd9999 -> r_bcd=20'h09999, r_ovf=0.
3. quotient=0, remainder=0 -> q_bcd=r_bcd=0, flags 0, out_valid still pulses once.
4. Start a conversion, pulse in_valid again at cycles +3 and +10 with different data -> the result matches the first operands only; exactly one out_valid.
5. Assert rst at cycle +8 of a conversion -> busy, out_valid, outputs all 0 immediately. After release, a new conversion of 16'd1234 gives 20'h01234 with normal 17-cycle latency.
6. Back-to-back: a second in_valid in the out_valid cycle (12345, 54321) -> second out_valid 17 cycles later with q_bcd=20'h12345, r_bcd=20'h54321. A random sweep of 1000 pairs must match the decimal model.

Source files
------------

// File: rtl/bin2bcd_converter_if.sv
// bin2bcd_converter_if: capture/result bundle between the divider and the BCD converter
interface bin2bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic                  busy;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  q_ovf;
  logic                  r_ovf;
  modport master (
    output in_valid, quotient, remainder,
    input  busy, out_valid, q_bcd, r_bcd, q_ovf, r_ovf
  );
  modport slave (
    input  in_valid, quotient, remainder,
    output busy, out_valid, q_bcd, r_bcd, q_ovf, r_ovf
  );
endinterface

// File: rtl/bin2bcd_converter.sv
// bin2bcd_converter: double-dabble conversion of quotient and remainder to packed BCD in lockstep
module bin2bcd_converter #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int DISP_DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  bin2bcd_converter_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_q_scr, r_r_scr;
  logic [BW-1:0]   w_q_adj, w_r_adj;
  logic [BW-1:0]   r_q_bcd, r_r_bcd;
  logic            r_q_ovf, r_r_ovf, r_out_valid;
  logic            w_busy;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign w_q_adj[4*g +: 4] = r_q_scr[WIDTH+4*g +: 4] >= 4'd5 ? r_q_scr[WIDTH+4*g +: 4] + 4'd3 : r_q_scr[WIDTH+4*g +: 4];
    assign w_r_adj[4*g +: 4] = r_r_scr[WIDTH+4*g +: 4] >= 4'd5 ? r_r_scr[WIDTH+4*g +: 4] + 4'd3 : r_r_scr[WIDTH+4*g +: 4];
    a_q_digit: assert property (@(posedge clk) disable iff (rst) r_q_scr[WIDTH+4*g +: 4] <= 4'd9);
    a_r_digit: assert property (@(posedge clk) disable iff (rst) r_r_scr[WIDTH+4*g +: 4] <= 4'd9);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state and busy; in_valid outside IDLE is ignored
  always_comb begin
    w_next = r_state;
    w_busy = r_state != IDLE;
    w_next = r_state == IDLE  ? (bus.in_valid ? SHIFT : IDLE) :
             r_state == SHIFT ? (r_cnt == LAST ? DONE : SHIFT) : IDLE;
  end
  // capture, add-3 then shift both scratch registers, publish results on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_q_scr     <= '0;
      r_r_scr     <= '0;
      r_q_bcd     <= '0;
      r_r_bcd     <= '0;
      r_q_ovf     <= 1'b0;
      r_r_ovf     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == IDLE && bus.in_valid) begin
        r_q_scr <= {{BW{1'b0}}, bus.quotient};
        r_r_scr <= {{BW{1'b0}}, bus.remainder};
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        r_q_scr <= {w_q_adj, r_q_scr[WIDTH-1:0]} << 1;
        r_r_scr <= {w_r_adj, r_r_scr[WIDTH-1:0]} << 1;
        r_cnt   <= r_cnt + 1'b1;
      end else if (r_state == DONE) begin
        r_q_bcd     <= r_q_scr[WIDTH +: BW];
        r_r_bcd     <= r_r_scr[WIDTH +: BW];
        r_q_ovf     <= |r_q_scr[SW-1 : WIDTH+4*DISP_DIGITS];
        r_r_ovf     <= |r_r_scr[SW-1 : WIDTH+4*DISP_DIGITS];
        r_out_valid <= 1'b1;
      end
    end
  end
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.q_bcd     = r_q_bcd;
  assign bus.r_bcd     = r_r_bcd;
  assign bus.q_ovf     = r_q_ovf;
  assign bus.r_ovf     = r_r_ovf;
endmodule

// File: tb/tb_bin2bcd_converter.sv
// tb_bin2bcd_converter: scoreboard bench against a decimal-digit reference model
module tb_bin2bcd_converter;
  typedef struct {
    logic [19:0] q;
    logic [19:0] r;
    logic        qo;
    logic        ro;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  exp_t sb[$];
  bin2bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus();
  bin2bcd_converter #(.WIDTH(16), .DIGITS(5), .DISP_DIGITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] b;
    int d;
    b = '0;
    d = v;
    for (int k = 0; k < 5; k++) begin
      b[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return b;
  endfunction
  function automatic exp_t model(input int q, input int r);
    exp_t e;
    e.q  = to_bcd(q);
    e.r  = to_bcd(r);
    e.qo = q >= 10000;
    e.ro = r >= 10000;
    return e;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      exp_t e;
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("q_bcd", 32'(bus.q_bcd), 32'(e.q));
        check("r_bcd", 32'(bus.r_bcd), 32'(e.r));
        check("q_ovf", 32'(bus.q_ovf), 32'(e.qo));
        check("r_ovf", 32'(bus.r_ovf), 32'(e.ro));
      end
    end
  end
  task automatic drive(input int q, input int r, input bit push);
    bus.in_valid  = 1'b1;
    bus.quotient  = q[15:0];
    bus.remainder = r[15:0];
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (push) sb.push_back(model(q, r));
  endtask
  task automatic timing();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'(i <= 16));
      check("out_valid", 32'(bus.out_valid), 32'(i == 17));
    end
  endtask
  task automatic wait_done();
    int n0;
    n0 = n_out;
    for (int c = 0; c < 40 && n_out == n0; c++) begin
      @(negedge clk);
      #1;
    end
    if (n_out == n0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no out_valid expected one within 40 cycles");
    end
  endtask
  function automatic int pick();
    int sp[6] = '{0, 9999, 10000, 65535, 1, 10};
    return $urandom_range(0, 7) == 0 ? sp[$urandom_range(0, 5)] : int'($urandom_range(0, 65535));
  endfunction
  initial begin
    int n0;
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_q_bcd", 32'(bus.q_bcd), 0);
    check("rst_r_bcd", 32'(bus.r_bcd), 0);
    check("rst_ovf", 32'({bus.q_ovf, bus.r_ovf}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(4660, 7, 1'b1);
    timing();
    drive(65535, 10000, 1'b1);
    wait_done();
    drive(0, 9999, 1'b1);
    wait_done();
    n0 = n_out;
    drive(0, 0, 1'b1);
    wait_done();
    check("zero_pulses", 32'(n_out - n0), 1);
    n0 = n_out;
    @(posedge clk);
    #1;
    drive(8421, 321, 1'b1);
    repeat (2) @(posedge clk);
    #1 drive(1111, 2222, 1'b0);
    repeat (6) @(posedge clk);
    #1 drive(3333, 4444, 1'b0);
    wait_done();
    repeat (20) @(negedge clk);
    check("ignored_pulses", 32'(n_out - n0), 1);
    @(posedge clk);
    #1;
    drive(5555, 6666, 1'b1);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_q_bcd", 32'(bus.q_bcd), 0);
    check("midrst_r_bcd", 32'(bus.r_bcd), 0);
    check("midrst_ovf", 32'({bus.q_ovf, bus.r_ovf}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1234, 0, 1'b1);
    timing();
    @(posedge clk);
    #1;
    drive(777, 888, 1'b1);
    timing();
    drive(12345, 54321, 1'b1);
    timing();
    for (int i = 0; i < 1000; i++) begin
      drive(pick(), pick(), 1'b1);
      wait_done();
    end
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
